// File: rtl/life_pkg.sv
// life_pkg: shared constants, FSM states and helpers for the 8x8 Life engine
package life_pkg;
  localparam int c_DIM = 8;
  localparam int c_ROW_W = 3;
  localparam logic [63:0] c_LFSR_TAPS = 64'hD800_0000_0000_0000;
  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;
  function automatic logic [5:0] bit_index(input logic [c_ROW_W-1:0] r, input logic [c_ROW_W-1:0] c);
    return {r, c};
  endfunction
endpackage

// File: rtl/life_row_calc.sv
// life_row_calc: next-generation row from three adjacent rows with column wrap
module life_row_calc
  import life_pkg::*;
(
  input  logic [c_DIM-1:0] above,
  input  logic [c_DIM-1:0] cur,
  input  logic [c_DIM-1:0] below,
  output logic [c_DIM-1:0] next_row
);
  for (genvar c = 0; c < c_DIM; c++) begin : g_col
    localparam int L = (c + c_DIM - 1) % c_DIM;
    localparam int R = (c + 1) % c_DIM;
    logic [3:0] n;
    assign n = 4'(above[L]) + 4'(above[c]) + 4'(above[R]) + 4'(cur[L]) + 4'(cur[R])
             + 4'(below[L]) + 4'(below[c]) + 4'(below[R]);
    assign next_row[c] = (n == 4'd3) || (n == 4'd2 && cur[c]);
  end
endmodule

// File: rtl/life_8x8_engine.sv
// life_8x8_engine: toroidal 8x8 Life stepper, one row per clock into a shadow frame; LIFE_AUTO_RESEED_EN reseeds dead/stagnant frames from an LFSR
module life_8x8_engine
  import life_pkg::*;
#(
  parameter int c_CNT_W = 16
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_Step,
  input  logic                   i_Seed_DV,
  input  logic [c_DIM*c_DIM-1:0] i_Seed_Data,
  output logic [c_DIM*c_DIM-1:0] o_Frame,
  output logic                   o_Busy,
  output logic                   o_Gen_Done,
  output logic                   o_Stable,
  output logic                   o_Empty,
  output logic [c_CNT_W-1:0]     o_Gen_Count,
  output logic                   o_Reseeded
);
  state_t state_q, state_d;
  logic [c_ROW_W-1:0] row_q;
  logic [c_DIM*c_DIM-1:0] shadow, commit_frame;
  logic [c_DIM-1:0] above, cur, below, next_row;
  logic calc, commit, reseed;
  assign calc = state_q == CALC;
  assign commit = state_q == COMMIT;
  assign above = o_Frame[bit_index(row_q - 3'd1, 3'd0) +: c_DIM];
  assign cur = o_Frame[bit_index(row_q, 3'd0) +: c_DIM];
  assign below = o_Frame[bit_index(row_q + 3'd1, 3'd0) +: c_DIM];
  assign o_Busy = state_q != IDLE;
  assign o_Empty = o_Frame == '0;
  life_row_calc u_row (.above(above), .cur(cur), .below(below), .next_row(next_row));
`ifdef LIFE_AUTO_RESEED_EN
  logic [63:0] lfsr;
  assign reseed = shadow == '0 || shadow == o_Frame;
  assign commit_frame = reseed ? lfsr : shadow;
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      lfsr <= 64'h1;
      o_Reseeded <= 1'b0;
    end else begin
      lfsr <= {1'b0, lfsr[63:1]} ^ (lfsr[0] ? c_LFSR_TAPS : '0);
      o_Reseeded <= commit && reseed && !i_Seed_DV;
    end
  end
`else
  assign reseed = 1'b0;
  assign commit_frame = shadow;
  assign o_Reseeded = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    state_d = i_Seed_DV ? IDLE
            : state_q == IDLE ? (i_Step ? CALC : IDLE)
            : calc ? (row_q == 3'd7 ? COMMIT : CALC)
            : IDLE;
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      row_q <= '0;
      shadow <= '0;
      o_Frame <= '0;
      o_Stable <= 1'b0;
      o_Gen_Count <= '0;
      o_Gen_Done <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= (calc && !i_Seed_DV) ? row_q + 3'd1 : '0;
      o_Gen_Done <= commit && !i_Seed_DV;
      if (i_Seed_DV) begin
        o_Frame <= i_Seed_Data;
        shadow <= '0;
        o_Stable <= 1'b0;
        o_Gen_Count <= '0;
      end else if (calc) begin
        shadow[bit_index(row_q, 3'd0) +: c_DIM] <= next_row;
      end else if (commit) begin
        o_Frame <= commit_frame;
        o_Stable <= !reseed && shadow == o_Frame;
        o_Gen_Count <= reseed ? '0 : (&o_Gen_Count) ? o_Gen_Count : o_Gen_Count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_life_8x8_engine.sv
// tb_life_8x8_engine: directed table-driven and sequence checks of the Life engine
module tb_life_8x8_engine;
  logic i_CLK = 0, i_RST = 0, i_Step = 0, i_Seed_DV = 0;
  logic [63:0] i_Seed_Data = '0;
  logic [63:0] o_Frame;
  logic o_Busy, o_Gen_Done, o_Stable, o_Empty, o_Reseeded;
  logic [15:0] o_Gen_Count;
  logic [63:0] lfsr_m, lfsr_prev;
  int errs = 0, checks = 0;
  typedef struct {
    logic [63:0] seed;
    logic [63:0] frame;
    logic        stable;
  } vec_t;
  vec_t vecs[7];
  life_8x8_engine dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_Step(i_Step), .i_Seed_DV(i_Seed_DV),
    .i_Seed_Data(i_Seed_Data), .o_Frame(o_Frame), .o_Busy(o_Busy),
    .o_Gen_Done(o_Gen_Done), .o_Stable(o_Stable), .o_Empty(o_Empty),
    .o_Gen_Count(o_Gen_Count), .o_Reseeded(o_Reseeded)
  );
  always #5 i_CLK = ~i_CLK;
  always @(posedge i_CLK) begin
    lfsr_prev <= lfsr_m;
    lfsr_m <= i_RST ? 64'h1 : ({1'b0, lfsr_m[63:1]} ^ (lfsr_m[0] ? 64'hD800_0000_0000_0000 : 64'h0));
  end
  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic seed(input logic [63:0] v);
    i_Seed_DV = 1;
    i_Seed_Data = v;
    tick();
    i_Seed_DV = 0;
  endtask
  task automatic step_wait(output int n, output int busy);
    i_Step = 1;
    tick();
    i_Step = 0;
    n = 0;
    busy = 0;
    while (!o_Gen_Done && n < 20) begin
      busy += int'(o_Busy);
      tick();
      n++;
    end
  endtask
  initial begin
    int n, busy, pulses;
    logic rs;
    logic [63:0] ef;
    vecs[0] = '{64'h0000_0000_1C00_0000, 64'h0000_0008_0808_0000, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_0303, 64'h0000_0000_0000_0303, 1'b1};
    vecs[2] = '{64'h0000_0000_0000_0083, 64'h0100_0000_0000_0101, 1'b0};
    vecs[3] = '{64'h0000_0000_0000_0001, 64'h0, 1'b0};
    vecs[4] = '{64'h0000_0000_0000_00FF, 64'hFF00_0000_0000_FFFF, 1'b0};
    vecs[5] = '{64'h0, 64'h0, 1'b1};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};
    i_RST = 1;
    tick();
    tick();
    check("rst_frame", o_Frame, 64'h0);
    check("rst_empty", 64'(o_Empty), 64'h1);
    check("rst_busy", 64'(o_Busy), 64'h0);
    check("rst_count", 64'(o_Gen_Count), 64'h0);
    check("rst_done", 64'(o_Gen_Done), 64'h0);
    check("rst_stable", 64'(o_Stable), 64'h0);
    i_RST = 0;
    tick();
    for (int i = 0; i < 7; i++) begin
      seed(vecs[i].seed);
      step_wait(n, busy);
      check($sformatf("v%0d_latency", i), 64'(n), 64'd9);
      check($sformatf("v%0d_busy", i), 64'(busy), 64'd9);
`ifdef LIFE_AUTO_RESEED_EN
      rs = vecs[i].frame == 64'h0 || vecs[i].stable;
`else
      rs = 1'b0;
`endif
      ef = rs ? lfsr_prev : vecs[i].frame;
      check($sformatf("v%0d_frame", i), o_Frame, ef);
      check($sformatf("v%0d_stable", i), 64'(o_Stable), 64'(rs ? 1'b0 : vecs[i].stable));
      check($sformatf("v%0d_count", i), 64'(o_Gen_Count), rs ? 64'd0 : 64'd1);
      check($sformatf("v%0d_empty", i), 64'(o_Empty), 64'(ef == 64'h0));
      check($sformatf("v%0d_reseeded", i), 64'(o_Reseeded), 64'(rs));
      tick();
      check($sformatf("v%0d_done_pulse", i), 64'(o_Gen_Done), 64'h0);
    end
    seed(64'h0000_0000_1C00_0000);
    step_wait(n, busy);
    step_wait(n, busy);
    check("blink2_frame", o_Frame, 64'h0000_0000_1C00_0000);
    check("blink2_count", 64'(o_Gen_Count), 64'd2);
    check("blink2_stable", 64'(o_Stable), 64'h0);
    seed(64'h0000_0000_1C00_0000);
    i_Step = 1;
    tick();
    i_Step = 0;
    tick();
    tick();
    i_Step = 1;
    tick();
    i_Step = 0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      pulses += int'(o_Gen_Done);
      tick();
    end
    check("ignore_pulses", 64'(pulses), 64'd1);
    check("ignore_frame", o_Frame, 64'h0000_0008_0808_0000);
    check("ignore_count", 64'(o_Gen_Count), 64'd1);
    seed(64'h0000_0000_1C00_0000);
    i_Step = 1;
    tick();
    i_Step = 0;
    tick();
    tick();
    tick();
    check("abort_busy_before", 64'(o_Busy), 64'h1);
    check("abort_frame_hold", o_Frame, 64'h0000_0000_1C00_0000);
    i_Seed_DV = 1;
    i_Seed_Data = 64'hFF;
    tick();
    i_Seed_DV = 0;
    check("abort_frame", o_Frame, 64'hFF);
    check("abort_busy", 64'(o_Busy), 64'h0);
    check("abort_count", 64'(o_Gen_Count), 64'h0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      pulses += int'(o_Gen_Done);
      tick();
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    check("abort_frame_kept", o_Frame, 64'hFF);
    i_Seed_DV = 1;
    i_Seed_Data = 64'h0303;
    i_Step = 1;
    tick();
    i_Seed_DV = 0;
    i_Step = 0;
    check("seed_wins_busy", 64'(o_Busy), 64'h0);
    check("seed_wins_frame", o_Frame, 64'h0303);
    step_wait(n, busy);
    i_Step = 1;
    tick();
    i_Step = 0;
    tick();
    tick();
    i_RST = 1;
    tick();
    i_RST = 0;
    check("midrst_busy", 64'(o_Busy), 64'h0);
    check("midrst_frame", o_Frame, 64'h0);
    check("midrst_count", 64'(o_Gen_Count), 64'h0);
    check("midrst_empty", 64'(o_Empty), 64'h1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
